// File: rtl/flop_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin write controller of the shared holding register.
package flop_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Next requester index in rotation; wraps n-1 -> 0 for any n, not just powers of two.
    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/flop_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/flop_rr_arbiter.sv
// Write controller for a shared WIDTH-bit register: round-robin grant with bounded burst length.
module flop_rr_arbiter
    import flop_rr_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t    state;
    logic [OW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic          pick_any;
    logic [OW-1:0] pick_idx;

    rr_pick #(.N(N_REQ), .IW(OW)) u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            q        <= '0;
            q_valid  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner    <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // Release either on the MAX_HOLD-th write or as soon as the owner drops req.
                    if (req[owner]) begin
                        q        <= wdata[int'(owner)*WIDTH +: WIDTH];
                        q_valid  <= 1'b1;
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                    if (!req[owner] || hold_cnt == HW'(MAX_HOLD - 1)) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= OW'(wrap_inc(int'(owner), N_REQ));
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
